sfpp_reconfig_master_0_b2p: RTL and testbench



---
 rtl/sfpp_reconfig_master_0_b2p.sv | 83 ++++++++
 tb/tb_sfpp_reconfig_master_0_b2p.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sfpp_reconfig_master_0_b2p.sv
// rtl/sfpp_reconfig_master_0_b2p.sv - escaped byte stream to Avalon-ST packet stream decoder
module sfpp_reconfig_master_0_b2p #(
   parameter int         CHANNEL_WIDTH = 8,
   parameter logic [7:0] SOP_CHAR      = 8'h7A,
   parameter logic [7:0] EOP_CHAR      = 8'h7B,
   parameter logic [7:0] CHAN_CHAR     = 8'h7C,
   parameter logic [7:0] ESC_CHAR      = 8'h7D
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [CHANNEL_WIDTH-1:0] out_channel
);

   logic                     sop_pend;
   logic                     eop_pend;
   logic                     chan_pend;
   logic                     esc_pend;
   logic [CHANNEL_WIDTH-1:0] channel_reg;
   logic                     accept;
   logic                     is_marker;
   logic [7:0]               value;

   assign in_ready = !out_valid || out_ready;

   // A byte following ESC_CHAR is always payload, even if it matches a marker.
   always_comb begin
      accept    = in_valid && in_ready;
      is_marker = !esc_pend && ((in_data == SOP_CHAR) || (in_data == EOP_CHAR) ||
                                (in_data == CHAN_CHAR) || (in_data == ESC_CHAR));
      value     = esc_pend ? (in_data ^ 8'h20) : in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid         <= 1'b0;
         out_data          <= 8'h00;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_channel       <= '0;
         sop_pend          <= 1'b0;
         eop_pend          <= 1'b0;
         chan_pend         <= 1'b0;
         esc_pend          <= 1'b0;
         channel_reg       <= '0;
      end else begin
         // Current beat is consumed (or absent); a new beat below re-asserts valid.
         if (in_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (is_marker) begin
               if (in_data == SOP_CHAR)  sop_pend  <= 1'b1;
               if (in_data == EOP_CHAR)  eop_pend  <= 1'b1;
               if (in_data == CHAN_CHAR) chan_pend <= 1'b1;
               if (in_data == ESC_CHAR)  esc_pend  <= 1'b1;
            end else begin
               esc_pend <= 1'b0;
               if (chan_pend) begin
                  channel_reg <= CHANNEL_WIDTH'(value);
                  chan_pend   <= 1'b0;
               end else begin
                  out_valid         <= 1'b1;
                  out_data          <= value;
                  out_startofpacket <= sop_pend;
                  out_endofpacket   <= eop_pend;
                  out_channel       <= channel_reg;
                  sop_pend          <= 1'b0;
                  eop_pend          <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sfpp_reconfig_master_0_b2p.sv
// tb/tb_sfpp_reconfig_master_0_b2p.sv - directed scoreboard bench for the byte-to-packet decoder
module tb_sfpp_reconfig_master_0_b2p;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_ready;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          out_ready = 1'b1;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_startofpacket;
   logic          out_endofpacket;
   logic [CW-1:0] out_channel;

   int errors = 0;
   int checks = 0;
   logic [7+2+CW:0] sb[$];

   sfpp_reconfig_master_0_b2p #(.CHANNEL_WIDTH(CW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_ready         (in_ready),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_startofpacket(out_startofpacket),
      .out_endofpacket  (out_endofpacket),
      .out_channel      (out_channel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_beat(input logic [7:0] d, input logic sop, input logic eop, input logic [CW-1:0] ch);
      sb.push_back({d, sop, eop, ch});
   endtask

   // Called on a falling edge; returns on the falling edge after the byte is accepted.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) check("send_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // A beat is taken by the sink on the rising edge following this sample.
   always @(negedge clk) begin
      logic [7+2+CW:0] got;
      #2;
      if (reset_n && out_valid === 1'b1 && out_ready === 1'b1) begin
         got = {out_data, out_startofpacket, out_endofpacket, out_channel};
         check("beat_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) check("beat", 32'(got), 32'(sb.pop_front()));
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
      check("rst_out_channel", 32'(out_channel), 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset_n = 1'b1;
      idle(1);

      // basic packet
      send(8'h7A); send(8'h7C); send(8'h03);
      check("marker_no_beat", {31'd0, out_valid}, 32'd0);
      exp_beat(8'h11, 1'b1, 1'b0, 8'h03); send(8'h11);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      check("latency_data", {24'd0, out_data}, 32'h11);
      exp_beat(8'h22, 1'b0, 1'b0, 8'h03); send(8'h22);
      send(8'h7B);
      check("marker_drops_valid", {31'd0, out_valid}, 32'd0);
      exp_beat(8'h33, 1'b0, 1'b1, 8'h03); send(8'h33);
      idle(2);

      // escapes, including an escaped channel byte
      send(8'h7A); send(8'h7D);
      exp_beat(8'h7A, 1'b1, 1'b0, 8'h03); send(8'h5A);
      send(8'h7B); send(8'h7D);
      exp_beat(8'h7D, 1'b0, 1'b1, 8'h03); send(8'h5D);
      send(8'h7C); send(8'h7D); send(8'h5C);
      send(8'h7A);
      exp_beat(8'h01, 1'b1, 1'b0, 8'h7C); send(8'h01);
      send(8'h7B);
      exp_beat(8'h02, 1'b0, 1'b1, 8'h7C); send(8'h02);
      idle(2);

      // backpressure while the second beat is pending
      send(8'h7A); send(8'h7C); send(8'h04);
      exp_beat(8'hA1, 1'b1, 1'b0, 8'h04); send(8'hA1);
      exp_beat(8'hA2, 1'b0, 1'b0, 8'h04); send(8'hA2);
      out_ready = 1'b0;
      in_data   = 8'hA3;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA2});
         @(negedge clk);
      end
      out_ready = 1'b1;
      exp_beat(8'hA3, 1'b0, 1'b0, 8'h04); send(8'hA3);
      send(8'h7B);
      exp_beat(8'hA4, 1'b0, 1'b1, 8'h04); send(8'hA4);
      idle(2);

      // marker inside channel sequence, channel persistence
      send(8'h7C); send(8'h7A); send(8'h05);
      exp_beat(8'h44, 1'b1, 1'b0, 8'h05); send(8'h44);
      send(8'h7A); send(8'h7A);
      exp_beat(8'h55, 1'b1, 1'b0, 8'h05); send(8'h55);
      send(8'h7B);
      exp_beat(8'h66, 1'b0, 1'b1, 8'h05); send(8'h66);
      idle(2);

      // single-byte packet
      send(8'h7A); send(8'h7B);
      exp_beat(8'h99, 1'b1, 1'b1, 8'h05); send(8'h99);
      idle(2);

      // asynchronous reset mid-packet
      send(8'h7A); send(8'h7C); send(8'h02);
      exp_beat(8'h11, 1'b1, 1'b0, 8'h02); send(8'h11);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_data", {24'd0, out_data}, 32'd0);
      check("arst_sop_eop", {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
      check("arst_channel", 32'(out_channel), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_beat(8'h22, 1'b0, 1'b0, 8'h00); send(8'h22);
      idle(3);

      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
